// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding selects,
// FSM encoding and register-file geometry.
package hazard_ctrl_pkg;

   localparam int REG_ADDR_W_DEF = 4;
   localparam int REG_FILE       = 1 << REG_ADDR_W_DEF;
   localparam int WORD           = 32;

   typedef enum logic [1:0] {
      SEL_RF      = 2'd0,
      SEL_EXE_MEM = 2'd1,
      SEL_WB      = 2'd2
   } fwd_sel_e;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hazard_slot.sv
// One shadow-pipeline slot: loads a tagged payload each edge unless held;
// reset clears the valid bit.
module hazard_slot #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         load_valid,
   input  logic [W-1:0] load_data,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         valid_d, valid_q;
   logic [W-1:0] data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (!hold) begin
         valid_d = load_valid;
         data_d  = load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/forward decisions from a shadow pipeline,
// memory-wait freeze and saturating performance counters.
//   state       | meaning
//   ST_RUN      | pipeline advancing normally
//   ST_MEM_WAIT | memory access in MEM outstanding, whole pipeline frozen
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  two_src,
   input  logic                  id_wb_en,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  fwd_en,
   input  logic                  flush,
   input  logic                  mem_ready,
   output logic                  freeze_if,
   output logic                  bubble_id,
   output logic                  freeze_all,
   output logic [1:0]            sel_src1,
   output logic [1:0]            sel_src2,
   output logic                  mem_wait,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      wait_cnt
);

   typedef struct packed {
      logic                  two_src;
      logic                  mem_write;
      logic                  mem_read;
      logic                  wb_en;
      logic [REG_ADDR_W-1:0] src2;
      logic [REG_ADDR_W-1:0] src1;
      logic [REG_ADDR_W-1:0] dest;
   } slot_t;

   localparam int SLOT_W = $bits(slot_t);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic hit(input logic v, input slot_t s,
                                input logic [REG_ADDR_W-1:0] x);
      return v & s.wb_en & (s.dest == x);
   endfunction

   slot_t     id_slot, s_exe, s_mem, s_wb;
   logic      exe_v, mem_v, wb_v;
   logic      exe_load_v, hazard;
   fwd_sel_e  sel1, sel2;
   hz_state_e state_d, state_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, wait_cnt_d, wait_cnt_q;
   logic      slot_unused;

   assign id_slot = '{two_src: two_src, mem_write: id_mem_write, mem_read: id_mem_read,
                      wb_en: id_wb_en, src2: src2, src1: src1, dest: id_dest};

   hazard_slot #(.W(SLOT_W)) u_slot_exe (
      .clk(clk), .rst(rst), .hold(freeze_all), .load_valid(exe_load_v),
      .load_data(id_slot), .valid(exe_v), .data(s_exe));
   hazard_slot #(.W(SLOT_W)) u_slot_mem (
      .clk(clk), .rst(rst), .hold(freeze_all), .load_valid(exe_v),
      .load_data(s_exe), .valid(mem_v), .data(s_mem));
   hazard_slot #(.W(SLOT_W)) u_slot_wb (
      .clk(clk), .rst(rst), .hold(freeze_all), .load_valid(mem_v),
      .load_data(s_mem), .valid(wb_v), .data(s_wb));

   assign freeze_all = mem_v & (s_mem.mem_read | s_mem.mem_write) & ~mem_ready;

   // With forwarding only a load still in EXE cannot be bypassed in time.
   always_comb begin
      hazard = 1'b0;
      if (fwd_en)
         hazard = (hit(exe_v, s_exe, src1) | (two_src & hit(exe_v, s_exe, src2)))
                  & s_exe.mem_read;
      else
         hazard = hit(exe_v, s_exe, src1) | (two_src & hit(exe_v, s_exe, src2))
                | hit(mem_v, s_mem, src1) | (two_src & hit(mem_v, s_mem, src2));
   end

   assign bubble_id  = hazard & ~flush & ~freeze_all;
   assign freeze_if  = bubble_id;
   assign exe_load_v = ~(bubble_id | flush);

   always_comb begin
      sel1 = SEL_RF;
      sel2 = SEL_RF;
      if (fwd_en && exe_v) begin
         if (hit(mem_v, s_mem, s_exe.src1) && !s_mem.mem_read) sel1 = SEL_EXE_MEM;
         else if (hit(wb_v, s_wb, s_exe.src1))                  sel1 = SEL_WB;
         if (s_exe.two_src) begin
            if (hit(mem_v, s_mem, s_exe.src2) && !s_mem.mem_read) sel2 = SEL_EXE_MEM;
            else if (hit(wb_v, s_wb, s_exe.src2))                  sel2 = SEL_WB;
         end
      end
   end

   assign sel_src1 = sel1;
   assign sel_src2 = sel2;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:      if (freeze_all) state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: if (mem_ready)  state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      if (bubble_id && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (freeze_all && wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign mem_wait  = (state_q == ST_MEM_WAIT);
   assign stall_cnt = stall_cnt_q;
   assign wait_cnt  = wait_cnt_q;

   // Payload fields carried along but not consulted at these stages.
   assign slot_unused = ^{s_exe.mem_write, s_mem.src1, s_mem.src2, s_mem.two_src,
                          s_wb.src1, s_wb.src2, s_wb.two_src, s_wb.mem_read, s_wb.mem_write};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected outputs are queued
// with the stimulus and compared at the falling edge.
module tb_hazard_ctrl;

   typedef struct packed {
      logic [3:0] d, s1, s2;
      logic       two, wb, mr, mw;
   } instr_t;

   typedef struct packed {
      instr_t      i;
      logic        fl, rdy, fwd;
      logic [51:0] e;
   } step_t;

   logic       clk, rst;
   logic [3:0] src1, src2, id_dest;
   logic       two_src, id_wb_en, id_mem_read, id_mem_write, fwd_en, flush, mem_ready;
   logic       freeze_if, bubble_id, freeze_all, mem_wait;
   logic [1:0] sel_src1, sel_src2;
   logic [15:0] stall_cnt, wait_cnt;
   logic       s_freeze_if, s_bubble_id, s_freeze_all, s_mem_wait;
   logic [1:0] s_sel_src1, s_sel_src2, s_stall_cnt, s_wait_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   step_t       stim_q[$];
   logic [51:0] exp_q[$];

   hazard_ctrl dut (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .id_dest(id_dest),
      .two_src(two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .fwd_en(fwd_en), .flush(flush), .mem_ready(mem_ready),
      .freeze_if(freeze_if), .bubble_id(bubble_id), .freeze_all(freeze_all),
      .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_wait(mem_wait),
      .stall_cnt(stall_cnt), .wait_cnt(wait_cnt));

   hazard_ctrl #(.CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .id_dest(id_dest),
      .two_src(two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .fwd_en(fwd_en), .flush(flush), .mem_ready(mem_ready),
      .freeze_if(s_freeze_if), .bubble_id(s_bubble_id), .freeze_all(s_freeze_all),
      .sel_src1(s_sel_src1), .sel_src2(s_sel_src2), .mem_wait(s_mem_wait),
      .stall_cnt(s_stall_cnt), .wait_cnt(s_wait_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam instr_t NOP = '0;

   function automatic instr_t alu(input logic [3:0] d, a, b);
      return '{d: d, s1: a, s2: b, two: 1'b1, wb: 1'b1, mr: 1'b0, mw: 1'b0};
   endfunction
   function automatic instr_t ldr(input logic [3:0] d, a);
      return '{d: d, s1: a, s2: 4'd0, two: 1'b0, wb: 1'b1, mr: 1'b1, mw: 1'b0};
   endfunction
   function automatic instr_t str(input logic [3:0] a, b);
      return '{d: 4'd0, s1: a, s2: b, two: 1'b1, wb: 1'b0, mr: 1'b0, mw: 1'b1};
   endfunction

   // Expected outputs of both instances; the 2-bit counters clip at 3.
   function automatic logic [51:0] ex(input logic b, fa, mw, input logic [1:0] s1, s2,
                                      input int sc, wc);
      int ssc, swc;
      ssc = (sc > 3) ? 3 : sc;
      swc = (wc > 3) ? 3 : wc;
      return {b, b, fa, mw, s1, s2, 16'(sc), 16'(wc), b, b, fa, mw, s1, s2, 2'(ssc), 2'(swc)};
   endfunction

   function automatic logic [51:0] obs();
      return {bubble_id, freeze_if, freeze_all, mem_wait, sel_src1, sel_src2, stall_cnt, wait_cnt,
              s_bubble_id, s_freeze_if, s_freeze_all, s_mem_wait, s_sel_src1, s_sel_src2,
              s_stall_cnt, s_wait_cnt};
   endfunction

   task automatic add_step(input instr_t i, input logic fl, rdy, fwd, input logic [51:0] e);
      stim_q.push_back('{i: i, fl: fl, rdy: rdy, fwd: fwd, e: e});
   endtask

   task automatic drive(input step_t s);
      src1 = s.i.s1; src2 = s.i.s2; id_dest = s.i.d; two_src = s.i.two;
      id_wb_en = s.i.wb; id_mem_read = s.i.mr; id_mem_write = s.i.mw;
      flush = s.fl; mem_ready = s.rdy; fwd_en = s.fwd;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive('{i: NOP, fl: 1'b0, rdy: 1'b1, fwd: 1'b0, e: '0});
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [51:0] o;
      rst = 1'b1;
      drive('{i: alu(4'd1, 4'd2, 4'd3), fl: 1'b0, rdy: 1'b0, fwd: 1'b1, e: '0});
      @(negedge clk);
      o = obs();
      n_tests++;
      if (o !== 52'd0) begin n_fail++; $display("FAIL reset_during: got %h expected 0", o); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      drive('{i: NOP, fl: 1'b0, rdy: 1'b0, fwd: 1'b1, e: '0});
      @(negedge clk);
      o = obs();
      n_tests++;
      if (o !== 52'd0) begin n_fail++; $display("FAIL reset_after: got %h expected 0", o); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall_only();
      step_t s; logic [51:0] e, o;
      do_reset();
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd2, 4'd1, 4'd3), 0, 1, 0, ex(1, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd2, 4'd1, 4'd3), 0, 1, 0, ex(1, 0, 0, 0, 0, 1, 0));
      add_step(alu(4'd2, 4'd1, 4'd3), 0, 1, 0, ex(0, 0, 0, 0, 0, 2, 0));
      add_step('{d: 4'd5, s1: 4'd6, s2: 4'd2, two: 1'b0, wb: 1'b1, mr: 1'b0, mw: 1'b0},
               0, 1, 0, ex(0, 0, 0, 0, 0, 2, 0));
      add_step(alu(4'd8, 4'd9, 4'd2), 0, 1, 0, ex(1, 0, 0, 0, 0, 2, 0));
      add_step(alu(4'd8, 4'd9, 4'd2), 0, 1, 0, ex(0, 0, 0, 0, 0, 3, 0));
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front(); drive(s); exp_q.push_back(s.e);
         @(negedge clk);
         e = exp_q.pop_front(); o = obs();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL stall_only step %0d: got %h expected %h", k, o, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_forward();
      step_t s; logic [51:0] e, o;
      do_reset();
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd2, 4'd1, 4'd3), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 1, 1, ex(0, 0, 0, 1, 0, 0, 0));
      add_step(alu(4'd6, 4'd7, 4'd8), 0, 1, 1, ex(0, 0, 0, 1, 0, 0, 0));
      add_step(alu(4'd2, 4'd1, 4'd3), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd4, 4'd1, 4'd1), 0, 1, 1, ex(0, 0, 0, 2, 0, 0, 0));
      add_step(NOP,                   0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd4, 4'd1, 4'd1), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(NOP,                   0, 1, 1, ex(0, 0, 0, 1, 1, 0, 0));
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd4, 4'd1, 4'd2), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(NOP,                   0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front(); drive(s); exp_q.push_back(s.e);
         @(negedge clk);
         e = exp_q.pop_front(); o = obs();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL forward step %0d: got %h expected %h", k, o, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      step_t s; logic [51:0] e, o;
      do_reset();
      add_step(ldr(4'd4, 4'd9),       0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd5, 4'd4, 4'd4), 0, 1, 1, ex(1, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd5, 4'd4, 4'd4), 0, 1, 1, ex(0, 0, 0, 0, 0, 1, 0));
      add_step(NOP,                   0, 1, 1, ex(0, 0, 0, 2, 2, 1, 0));
      add_step(NOP,                   0, 1, 1, ex(0, 0, 0, 0, 0, 1, 0));
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front(); drive(s); exp_q.push_back(s.e);
         @(negedge clk);
         e = exp_q.pop_front(); o = obs();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL load_use step %0d: got %h expected %h", k, o, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush();
      step_t s; logic [51:0] e, o;
      do_reset();
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd2, 4'd1, 4'd3), 1, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd7, 4'd2, 4'd5), 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(NOP,                   0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front(); drive(s); exp_q.push_back(s.e);
         @(negedge clk);
         e = exp_q.pop_front(); o = obs();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL flush step %0d: got %h expected %h", k, o, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait();
      step_t s; logic [51:0] e, o;
      do_reset();
      add_step(str(4'd3, 4'd4),       0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(NOP,                   0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 0, 0, ex(0, 1, 0, 0, 0, 0, 0));
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 0, 0, ex(0, 1, 1, 0, 0, 0, 1));
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 0, 0, ex(0, 1, 1, 0, 0, 0, 2));
      add_step(alu(4'd1, 4'd2, 4'd3), 0, 1, 0, ex(0, 0, 1, 0, 0, 0, 3));
      add_step(alu(4'd2, 4'd1, 4'd3), 0, 1, 0, ex(1, 0, 0, 0, 0, 0, 3));
      add_step(NOP,                   0, 1, 0, ex(0, 0, 0, 0, 0, 1, 3));
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front(); drive(s); exp_q.push_back(s.e);
         @(negedge clk);
         e = exp_q.pop_front(); o = obs();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL mem_wait step %0d: got %h expected %h", k, o, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_saturate();
      step_t s; logic [51:0] e, o;
      int sc;
      do_reset();
      sc = 0;
      for (int r = 0; r < 3; r++) begin
         add_step(alu(4'd1, 4'd2, 4'd3), 0, 1, 0, ex(0, 0, 0, 0, 0, sc, 0));
         add_step(alu(4'd2, 4'd1, 4'd3), 0, 1, 0, ex(1, 0, 0, 0, 0, sc, 0)); sc++;
         add_step(alu(4'd2, 4'd1, 4'd3), 0, 1, 0, ex(1, 0, 0, 0, 0, sc, 0)); sc++;
      end
      add_step(NOP, 0, 1, 0, ex(0, 0, 0, 0, 0, sc, 0));
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front(); drive(s); exp_q.push_back(s.e);
         @(negedge clk);
         e = exp_q.pop_front(); o = obs();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL saturate step %0d: got %h expected %h", k, o, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_in_wait();
      step_t s; logic [51:0] e, o;
      do_reset();
      add_step(str(4'd3, 4'd4), 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(NOP,             0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
      add_step(NOP,             0, 0, 0, ex(0, 1, 0, 0, 0, 0, 0));
      add_step(NOP,             0, 0, 0, ex(0, 1, 1, 0, 0, 0, 1));
      for (int k = 0; stim_q.size() > 0; k++) begin
         s = stim_q.pop_front(); drive(s); exp_q.push_back(s.e);
         @(negedge clk);
         e = exp_q.pop_front(); o = obs();
         n_tests++;
         if (o !== e) begin n_fail++; $display("FAIL rst_wait step %0d: got %h expected %h", k, o, e); end
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1 o = obs();
      n_tests++;
      if (o !== 52'd0) begin n_fail++; $display("FAIL rst_wait_async: got %h expected 0", o); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         o = obs();
         n_tests++;
         if (o !== 52'd0) begin n_fail++; $display("FAIL rst_wait_after %0d: got %h expected 0", k, o); end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      drive('{i: NOP, fl: 1'b0, rdy: 1'b1, fwd: 1'b0, e: '0});
      test_reset();
      test_stall_only();
      test_forward();
      test_load_use();
      test_flush();
      test_mem_wait();
      test_saturate();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
